// File: rtl/count_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// count_ctrl_pkg
// Shared types and default sizes for the count_ctrl controller and its
// count_core datapath.
//   state_t        : controller states IDLE, ARMED, RUN, DONE
//   DEFAULT_WIDTH  : default counter / load-value width
//   DEFAULT_MISS_W : default width of the saturating missed-event counter
// ---------------------------------------------------------------------------
package count_ctrl_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_MISS_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/count_core.sv
// ---------------------------------------------------------------------------
// count_core
// Loadable down-counter register with zero detect.
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_value this cycle (wins over dec)
//   load_value : value to load
//   dec        : decrement enable; ignored when the count is already zero
//   count      : current counter value
//   zero       : count == 0
// ---------------------------------------------------------------------------
module count_core
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    // The zero guard keeps the counter from ever wrapping even if the
    // controller asserts dec at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/count_ctrl.sv
// ---------------------------------------------------------------------------
// count_ctrl
// Sequencing controller for the loadable down-counter. Loads a value over a
// valid/ready config handshake, arms, counts down on tick while running and
// reports each terminal count on a held valid/ready event channel. Supports
// one-shot and auto-reload and counts events lost to back-pressure.
//   clk, rst    : clock, asynchronous active-high reset
//   cfg_valid   : load request
//   cfg_ready   : controller can accept a load (IDLE or ARMED)
//   cfg_value   : load value, period = cfg_value + 1 ticks
//   cfg_auto    : 1 = auto-reload, 0 = one-shot
//   start       : start request, honoured only in ARMED
//   stop        : abort request, honoured in ARMED and RUN
//   tick        : count enable
//   count       : current counter value
//   busy        : high in RUN
//   done_valid  : terminal-count event pending
//   done_ready  : event consumer acknowledge
//   missed      : saturating count of events dropped while done_valid held
// ---------------------------------------------------------------------------
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int MISS_W = DEFAULT_MISS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_value,
    input  logic              cfg_auto,
    input  logic              start,
    input  logic              stop,
    input  logic              tick,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [MISS_W-1:0] missed
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] reload;
    logic             auto_mode;
    logic             zero;
    logic             accept;
    logic             run_tick;
    logic             terminal;
    logic             ack;
    logic             core_load;
    logic [WIDTH-1:0] core_value;
    logic             core_dec;

    // Both decoded straight from the state register so neither has a
    // combinational path from any input.
    assign cfg_ready = (state == IDLE) || (state == ARMED);
    assign busy      = (state == RUN);

    assign accept   = cfg_valid && cfg_ready;
    // stop masks the tick so an abort coinciding with terminal produces
    // neither an event nor a reload, and the count simply holds.
    assign run_tick = (state == RUN) && tick && !stop;
    assign terminal = run_tick && zero;
    assign ack      = done_valid && done_ready;

    // A config accept and an auto-reload can never coincide: accept only
    // happens outside RUN and terminal only inside it.
    assign core_load  = accept || (terminal && auto_mode);
    assign core_value = accept ? cfg_value : reload;
    assign core_dec   = run_tick && !zero;

    count_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load       (core_load),
        .load_value (core_value),
        .dec        (core_dec),
        .count      (count),
        .zero       (zero)
    );

    // Reload value and mode are captured together on every accepted load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload    <= '0;
            auto_mode <= 1'b0;
        end else if (accept) begin
            reload    <= cfg_value;
            auto_mode <= cfg_auto;
        end
    end

    // Event channel: a new event either fills an empty slot or replaces one
    // being acknowledged this cycle; otherwise it is lost and counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_valid <= 1'b0;
            missed     <= '0;
        end else begin
            if (terminal) begin
                done_valid <= 1'b1;
                if (done_valid && !done_ready && (missed != '1)) begin
                    missed <= missed + 1'b1;
                end
            end else if (ack) begin
                done_valid <= 1'b0;
            end
            if (accept) begin
                missed <= '0;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. In ARMED, stop outranks start; a load accepted in
    // the same cycle as stop still updates the count and reload registers.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (terminal && !auto_mode) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_count_ctrl
// Directed testbench for count_ctrl. Stimulus pushes the expected snapshot
// of each terminal event into a scoreboard queue; an independent monitor
// pops and compares whenever an event is handed off (done_valid & done_ready).
// Other observable state is checked directly after each stimulus cycle.
// ---------------------------------------------------------------------------
module tb_count_ctrl;

    typedef struct packed {
        logic [15:0] count;
        logic [7:0]  missed;
        logic        busy;
    } event_t;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_value;
    logic        cfg_auto;
    logic        start;
    logic        stop;
    logic        tick;
    logic [15:0] count;
    logic        busy;
    logic        done_valid;
    logic        done_ready;
    logic [7:0]  missed;

    event_t sb[$];
    int     tests_run;
    int     tests_failed;

    count_ctrl #(
        .WIDTH  (16),
        .MISS_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_value  (cfg_value),
        .cfg_auto   (cfg_auto),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .count      (count),
        .busy       (busy),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .missed     (missed)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one full cycle of inputs, then settle just after the edge.
    task automatic applyStimulus(input logic cv, input logic [15:0] val,
                                 input logic au, input logic st,
                                 input logic sp, input logic tk,
                                 input logic dr);
        cfg_valid  = cv;
        cfg_value  = val;
        cfg_auto   = au;
        start      = st;
        stop       = sp;
        tick       = tk;
        done_ready = dr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushEvent(input logic [15:0] c, input logic [7:0] m,
                             input logic b);
        event_t e;
        e.count  = c;
        e.missed = m;
        e.busy   = b;
        sb.push_back(e);
    endtask

    // Monitor: every handoff on the event channel must match the oldest
    // expected snapshot.
    always @(negedge clk) begin
        if (!rst && done_valid && done_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL event_unexpected: got count=%0d missed=%0d, expected no event",
                         count, missed);
            end else begin
                event_t e;
                e = sb.pop_front();
                if ({count, missed, busy} !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL event_data: got count=%0d missed=%0d busy=%0d, expected count=%0d missed=%0d busy=%0d",
                             count, missed, busy, e.count, e.missed, e.busy);
                end
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_value  = '0;
        cfg_auto   = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        tick       = 1'b0;
        done_ready = 1'b0;

        // Reset values.
        #12;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_done_valid", done_valid, 0);
        checkOutput("rst_missed", missed, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_cfg_ready", cfg_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One-shot, load 3, tick held high.
        applyStimulus(1, 16'd3, 0, 0, 0, 0, 0);
        checkOutput("t1_armed_count", count, 3);
        checkOutput("t1_armed_cfg_ready", cfg_ready, 1);
        checkOutput("t1_armed_busy", busy, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("t1_run_busy", busy, 1);
        checkOutput("t1_run_cfg_ready", cfg_ready, 0);
        checkOutput("t1_run_count", count, 3);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            checkOutput("t1_count", count, (i >= 3) ? 0 : 3 - i);
            checkOutput("t1_done_valid", done_valid, (i == 4) ? 1 : 0);
        end
        checkOutput("t1_done_busy", busy, 0);
        checkOutput("t1_done_cfg_ready", cfg_ready, 0);
        pushEvent(16'd0, 8'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t1_ack_done_valid", done_valid, 0);
        checkOutput("t1_idle_cfg_ready", cfg_ready, 1);

        // Auto-reload, load 2, consumer always ready: event every 3 ticks.
        applyStimulus(1, 16'd2, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            pushEvent(16'd2, 8'd0, 1'b1);
        end
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 1);
            checkOutput("t2_done_valid", done_valid, (i % 3 == 0) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        checkOutput("t2_stop_count", count, 2);
        checkOutput("t2_stop_busy", busy, 0);
        checkOutput("t2_missed", missed, 0);
        checkOutput("t2_stop_done_valid", done_valid, 0);

        // Auto-reload, load 0, consumer stalled: events lost and counted.
        applyStimulus(1, 16'd0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            checkOutput("t3_missed", missed, i - 1);
            checkOutput("t3_done_valid", done_valid, 1);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("t3_stop_busy", busy, 0);
        checkOutput("t3_stop_missed", missed, 4);
        checkOutput("t3_stop_done_valid", done_valid, 1);
        applyStimulus(1, 16'd7, 0, 0, 0, 0, 0);
        checkOutput("t3_load_missed", missed, 0);
        checkOutput("t3_load_count", count, 7);
        checkOutput("t3_load_done_valid", done_valid, 1);
        pushEvent(16'd7, 8'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t3_ack_done_valid", done_valid, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checkOutput("t3_idle_cfg_ready", cfg_ready, 1);

        // One-shot, load 5, tick toggling 0/1: terminal on cycle 12.
        applyStimulus(1, 16'd5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(0, 0, 0, 0, 0, (i % 2 == 0), 0);
            checkOutput("t4_count", count, (i < 10) ? 5 - i / 2 : 0);
            checkOutput("t4_done_valid", done_valid, (i == 12) ? 1 : 0);
        end
        checkOutput("t4_done_busy", busy, 0);
        pushEvent(16'd0, 8'd0, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        // Rerun with stop landing on the terminal tick.
        applyStimulus(1, 16'd5, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
        end
        checkOutput("t4r_count_zero", count, 0);
        checkOutput("t4r_busy", busy, 1);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        checkOutput("t4r_stop_done_valid", done_valid, 0);
        checkOutput("t4r_stop_count", count, 0);
        checkOutput("t4r_stop_busy", busy, 0);
        checkOutput("t4r_stop_cfg_ready", cfg_ready, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("t4r_idle_done_valid", done_valid, 0);

        // Asynchronous reset mid-RUN with an event pending and one missed.
        applyStimulus(1, 16'd1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("t5_pre_count", count, 1);
        checkOutput("t5_pre_done_valid", done_valid, 1);
        checkOutput("t5_pre_missed", missed, 1);
        checkOutput("t5_pre_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t5_rst_count", count, 0);
        checkOutput("t5_rst_done_valid", done_valid, 0);
        checkOutput("t5_rst_missed", missed, 0);
        checkOutput("t5_rst_busy", busy, 0);
        checkOutput("t5_rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 1, 0);
        checkOutput("t5_post_busy", busy, 0);

        // Missed counter saturation.
        applyStimulus(1, 16'd0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, 0);
            if (i == 255) begin
                checkOutput("t6_missed_254", missed, 254);
            end
        end
        checkOutput("t6_missed_sat", missed, 255);
        checkOutput("t6_done_valid", done_valid, 1);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        pushEvent(16'd0, 8'd255, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checkOutput("t6_ack_done_valid", done_valid, 0);

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
